// File: rtl/fp_mul_pkg.sv
// fp_mul_pkg: shared widths, field positions and FSM states for the iterative FP multiplier
package fp_mul_pkg;
    localparam int EXP_W  = 8;
    localparam int MAN_W  = 23;
    localparam int BIAS   = 127;
    localparam int W      = 1 + EXP_W + MAN_W;
    localparam int SIG_W  = MAN_W + 1;
    localparam int PROD_W = 2 * SIG_W;
    localparam int CNT_W  = $clog2(SIG_W + 1);
    localparam int E_W    = EXP_W + 2;
    localparam int SIGN_B = W - 1;
    localparam int EXP_HI = W - 2;
    localparam int EXP_LO = MAN_W;
    localparam logic signed [E_W-1:0] E_MAX = E_W'((1 << EXP_W) - 1);
    typedef enum logic [1:0] {IDLE, ITER, NORM, DONE} state_t;
    function automatic logic [SIG_W-1:0] sig_of(input logic [W-1:0] x);
        return {1'b1, x[MAN_W-1:0]};
    endfunction
endpackage

// File: rtl/fp_norm_round.sv
// fp_norm_round: normalize, round and pack the raw significand product
// FPMUL_ROUND_RNE_EN selects round-to-nearest-even; otherwise the mantissa is truncated
module fp_norm_round
    import fp_mul_pkg::*;
(
    input  logic [PROD_W-1:0]       prod,
    input  logic signed [E_W-1:0]   e_sum,
    input  logic                    sign,
    output logic [W-1:0]            res,
    output logic                    ovf,
    output logic                    unf
);
    logic                  msb;
    logic [MAN_W-1:0]      man_t, man;
    logic signed [E_W-1:0] e_n, e;
    assign msb   = prod[PROD_W-1];
    assign e_n   = e_sum + $signed({{(E_W-1){1'b0}}, msb});
    assign man_t = msb ? prod[PROD_W-2 -: MAN_W] : prod[PROD_W-3 -: MAN_W];
`ifdef FPMUL_ROUND_RNE_EN
    logic g, s, rnd, cy;
    assign g   = msb ? prod[SIG_W-1] : prod[SIG_W-2];
    assign s   = msb ? |prod[SIG_W-2:0] : |prod[SIG_W-3:0];
    assign rnd = g & (s | man_t[0]);
    // an all-ones mantissa rounding up wraps to 1.0 of the next binade
    assign {cy, man} = {1'b0, man_t} + (MAN_W+1)'(rnd);
    assign e   = e_n + $signed({{(E_W-1){1'b0}}, cy});
`else
    assign man = man_t;
    assign e   = e_n;
`endif
    assign ovf = e >= E_MAX;
    assign unf = e[E_W-1] | (e == '0);
    assign res = ovf ? {sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}}
               : unf ? {sign, {(W-1){1'b0}}}
               : {sign, e[EXP_W-1:0], man};
endmodule

// File: rtl/fp_mul_datapath.sv
// fp_mul_datapath: shift-add single-precision multiplier datapath driven by Init_En/WE/RE
// rounding mode set by FPMUL_ROUND_RNE_EN inside fp_norm_round
module fp_mul_datapath
    import fp_mul_pkg::*;
(
    input  logic         CLK,
    input  logic         Reset,
    input  logic         Init_En,
    input  logic         WE,
    input  logic         RE,
    input  logic [W-1:0] A,
    input  logic [W-1:0] B,
    output logic         DoneC,
    output logic [W-1:0] Result,
    output logic [1:0]   Flags
);
    state_t                state, state_nx;
    logic                  sign_q, zero_q, done_q;
    logic [EXP_W-1:0]      ea_q, eb_q;
    logic [SIG_W-1:0]      mcand_q, mplier_q;
    logic [PROD_W-1:0]     prod_q;
    logic [CNT_W-1:0]      cnt_q;
    logic [W-1:0]          res_q, nr_res;
    logic [1:0]            flags_q;
    logic                  nr_ovf, nr_unf;
    logic signed [E_W-1:0] e_sum;
    logic                  step, norm;
    assign step  = WE && state == ITER;
    assign norm  = WE && state == NORM;
    assign e_sum = $signed({2'b00, ea_q}) + $signed({2'b00, eb_q}) - $signed(E_W'(BIAS));
    fp_norm_round u_nr (
        .prod  (prod_q),
        .e_sum (e_sum),
        .sign  (sign_q),
        .res   (nr_res),
        .ovf   (nr_ovf),
        .unf   (nr_unf)
    );
    always_ff @(posedge CLK or posedge Reset)
        if (Reset) state <= IDLE;
        else       state <= state_nx;
    always_comb begin
        state_nx = Init_En ? ITER
                 : (step && cnt_q == CNT_W'(SIG_W - 1)) ? NORM
                 : norm ? DONE
                 : state;
    end
    // zero operands still run the full iteration so latency never depends on data
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            sign_q   <= 1'b0;
            zero_q   <= 1'b0;
            ea_q     <= '0;
            eb_q     <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            prod_q   <= '0;
            cnt_q    <= '0;
            res_q    <= '0;
            flags_q  <= '0;
            done_q   <= 1'b0;
        end else if (Init_En) begin
            sign_q   <= A[SIGN_B] ^ B[SIGN_B];
            zero_q   <= (A[EXP_HI:EXP_LO] == '0) || (B[EXP_HI:EXP_LO] == '0);
            ea_q     <= A[EXP_HI:EXP_LO];
            eb_q     <= B[EXP_HI:EXP_LO];
            mcand_q  <= sig_of(A);
            mplier_q <= sig_of(B);
            prod_q   <= '0;
            cnt_q    <= '0;
            done_q   <= 1'b0;
        end else if (step) begin
            if (mplier_q[0]) prod_q <= prod_q + (PROD_W'(mcand_q) << cnt_q);
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q + CNT_W'(1);
        end else if (norm) begin
            res_q    <= zero_q ? {sign_q, {(W-1){1'b0}}} : nr_res;
            flags_q  <= zero_q ? 2'b00 : {nr_ovf, nr_unf};
            done_q   <= 1'b1;
        end
    end
    assign DoneC  = done_q;
    assign Flags  = flags_q;
    assign Result = RE ? res_q : '0;
endmodule

// File: tb/tb_fp_mul_datapath.sv
// tb_fp_mul_datapath: directed vectors with hand-computed products, latency and control checks
module tb_fp_mul_datapath;
    logic        CLK = 1'b0;
    logic        Reset, Init_En, WE, RE;
    logic [31:0] A, B, Result;
    logic [1:0]  Flags;
    logic        DoneC;
    int          n_vec = 0;
    int          n_err = 0;
    int          lat;

    always #5 CLK = ~CLK;

    fp_mul_datapath dut (
        .CLK     (CLK),
        .Reset   (Reset),
        .Init_En (Init_En),
        .WE      (WE),
        .RE      (RE),
        .A       (A),
        .B       (B),
        .DoneC   (DoneC),
        .Result  (Result),
        .Flags   (Flags)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // pulse Init_En one cycle, then count WE-gated edges until DoneC, optionally pausing WE
    task automatic op(input logic [31:0] a, input logic [31:0] b,
                      input int pause_at, input int pause_len, output int n);
        @(negedge CLK);
        Init_En = 1'b1; A = a; B = b; WE = 1'b1;
        @(negedge CLK);
        Init_En = 1'b0;
        n = 0;
        while (!DoneC && n < 100) begin
            WE = !(n >= pause_at && n < pause_at + pause_len);
            @(posedge CLK);
            #1 n++;
        end
        WE = 1'b1;
        @(negedge CLK);
    endtask

    initial begin
        Reset = 1'b1; Init_En = 1'b0; WE = 1'b0; RE = 1'b1; A = '0; B = '0;
        #2;
        chk("rst_done", {31'b0, DoneC}, 32'd0);
        chk("rst_result", Result, 32'h0);
        chk("rst_flags", {30'b0, Flags}, 32'd0);
        @(negedge CLK); @(negedge CLK);
        Reset = 1'b0;

        op(32'h3FC00000, 32'h40000000, 1000, 0, lat);
        chk("lat_1p5x2", lat, 25);
        chk("res_1p5x2", Result, 32'h40400000);
        chk("flg_1p5x2", {30'b0, Flags}, 32'd0);

        op(32'hC0200000, 32'h40800000, 1000, 0, lat);
        chk("lat_neg", lat, 25);
        chk("res_neg", Result, 32'hC1200000);

        op(32'h80000000, 32'h3F800000, 1000, 0, lat);
        chk("lat_zero", lat, 25);
        chk("res_zero", Result, 32'h80000000);
        chk("flg_zero", {30'b0, Flags}, 32'd0);

        op(32'h00800000, 32'h00800000, 1000, 0, lat);
        chk("res_unf", Result, 32'h00000000);
        chk("flg_unf", {30'b0, Flags}, 32'd1);

        op(32'h3F800001, 32'h3FC00000, 1000, 0, lat);
`ifdef FPMUL_ROUND_RNE_EN
        chk("res_round", Result, 32'h3FC00002);
`else
        chk("res_round", Result, 32'h3FC00001);
`endif

        op(32'h7F000000, 32'h7F000000, 1000, 0, lat);
        chk("res_ovf", Result, 32'h7F800000);
        chk("flg_ovf", {30'b0, Flags}, 32'd2);
        // DONE holds with WE high; RE gates only Result
        repeat (3) @(negedge CLK);
        chk("done_hold", {31'b0, DoneC}, 32'd1);
        chk("res_hold", Result, 32'h7F800000);
        RE = 1'b0;
        #1;
        chk("re0_result", Result, 32'h0);
        chk("re0_done", {31'b0, DoneC}, 32'd1);
        chk("re0_flags", {30'b0, Flags}, 32'd2);
        RE = 1'b1;

        op(32'hC0200000, 32'h40800000, 8, 5, lat);
        chk("lat_pause", lat, 30);
        chk("res_pause", Result, 32'hC1200000);

        // abort at step 10 by re-asserting Init_En with new operands
        @(negedge CLK);
        Init_En = 1'b1; A = 32'hC0200000; B = 32'h40800000; WE = 1'b1;
        @(negedge CLK);
        Init_En = 1'b0;
        chk("init_clr_done", {31'b0, DoneC}, 32'd0);
        repeat (10) @(negedge CLK);
        chk("abort_res_kept", Result, 32'hC1200000);
        Init_En = 1'b1; A = 32'h3FC00000; B = 32'h40000000;
        @(negedge CLK);
        Init_En = 1'b0;
        lat = 0;
        while (!DoneC && lat < 100) begin
            @(posedge CLK);
            #1 lat++;
        end
        chk("lat_restart", lat, 25);
        chk("res_restart", Result, 32'h40400000);

        // asynchronous reset mid-operation
        @(negedge CLK);
        Init_En = 1'b1; A = 32'hC0200000; B = 32'h40800000;
        @(negedge CLK);
        Init_En = 1'b0;
        repeat (10) @(posedge CLK);
        #3 Reset = 1'b1;
        #1;
        chk("arst_result", Result, 32'h0);
        chk("arst_done", {31'b0, DoneC}, 32'd0);
        chk("arst_flags", {30'b0, Flags}, 32'd0);
        @(negedge CLK);
        Reset = 1'b0;
        repeat (30) @(negedge CLK);
        chk("idle_we_ignored", {31'b0, DoneC}, 32'd0);
        chk("idle_result", Result, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
